pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Parametrised game core for the Pong logic layer: ball motion, both paddles, scoring and a match state machine (idle, serve, play, point, game over) in one registered block. It replaces the fixed per-function controllers with one unit whose screen geometry, speeds and winning score are parameters. It adds serve delay, serve-toward-loser and end-of-match detection. It sits between the input/UART pad sources and the drawing pipeline. It is clocked by the pixel-domain clock and advanced by the frame `timing_tick`.

## Interface
Parameters:
- `SCREEN_W`, 800: playfield width, pixels.
- `SCREEN_H`, 600: playfield height, pixels.
- `PAD_H`, 100: paddle height.
- `PAD_W`, 10: paddle width.
- `PAD_X_LEFT`, 20: left paddle x, left edge.
- `PAD_X_RIGHT`, 770: right paddle x, left edge.
- `BALL_SIZE`, 10: ball side length.
- `BALL_SPEED`, 4: ball step per tick on each axis.
- `PAD_SPEED`, 6: paddle step per tick.
- `WIN_SCORE`, 9: points needed to win; range 1..2^SCORE_W-1.
- `SCORE_W`, 4: score width.
- `SERVE_DELAY`, 60: ticks the ball is held at centre before play.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `timing_tick` in 1: one-cycle frame strobe.
- `start` in 1: level; begins a match.
- `p1_up`, `p1_down` in 1 each: left paddle controls.
- `p2_up`, `p2_down` in 1 each: right paddle controls.
- `x_ball` out 11: ball top-left x.
- `y_ball` out 10: ball top-left y.
- `y_player1`, `y_player2` out 10 each: paddle top y.
- `player1_score`, `player2_score` out SCORE_W each.
- `game_state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- `winner` out 2: 0 none, 1 player1, 2 player2.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `x_ball`=(SCREEN_W-BALL_SIZE)/2 (395), `y_ball`=(SCREEN_H-BALL_SIZE)/2 (295).
  - Both paddles at (SCREEN_H-PAD_H)/2 (250).
  - Scores 0, `winner` 0.
  - Ball direction right/down; serve counter 0.
- `start` is sampled on any cycle in IDLE or GAME_OVER. Next cycle: state SERVE, scores cleared, `winner` 0, ball centred, counter 0. `start` is ignored in other states.
- Everything below advances only on cycles with `timing_tick`=1.
- Paddles move in SERVE and PLAY only.
  - up&!down: y -= PAD_SPEED, saturating at 0.
  - down&!up: y += PAD_SPEED, saturating at SCREEN_H-PAD_H (500).
  - Both or neither pressed: hold.
- SERVE:
  - Ball is held at centre.
  - The counter increments each tick; on the tick where it equals SERVE_DELAY-1, go to PLAY and clear the counter.
  - Horizontal direction points toward the player who lost the last point (right for the first serve).
  - Vertical direction is kept from the previous rally.
- PLAY: the x and y axes are evaluated independently in the same tick.
  - Y axis, walls:
    - Moving up and y < BALL_SPEED: y=0, direction becomes down.
    - Moving down and y+BALL_SPEED > SCREEN_H-BALL_SIZE: y=590, direction becomes up.
    - Otherwise y ± BALL_SPEED.
  - Vertical overlap with a paddle at y_pad is defined as y_ball+BALL_SIZE > y_pad and y_ball < y_pad+PAD_H, using pre-tick values.
  - Left paddle hit: moving left, x ≥ PAD_X_LEFT+PAD_W, x-BALL_SPEED ≤ PAD_X_LEFT+PAD_W, and vertical overlap. Then x=PAD_X_LEFT+PAD_W (30) and direction becomes right.
  - Right paddle hit: mirror of the left rule, with face PAD_X_RIGHT. Then x=PAD_X_RIGHT-BALL_SIZE (760) and direction becomes left.
  - A paddle hit takes priority over a miss.
  - Left miss: moving left and x < BALL_SPEED. Then x=0, `player2_score`+1, serve direction = left, go to POINT.
  - Right miss: moving right and x+BALL_SPEED > SCREEN_W-BALL_SIZE. Then x=790, `player1_score`+1, serve direction = right, go to POINT.
  - Otherwise x ± BALL_SPEED.
- POINT lasts one tick:
  - If the scorer's score equals WIN_SCORE: go to GAME_OVER and set `winner`.
  - Otherwise: ball recentred, go to SERVE.
- GAME_OVER: all positions and scores hold until `start`.
- Score arithmetic never wraps, because GAME_OVER is reached at WIN_SCORE.

## Timing
- Tick-driven updates are visible on the cycle after the tick edge.
- `start` takes effect one cycle after sampling and does not need a tick.
- Phase durations:
  - SERVE: exactly SERVE_DELAY ticks.
  - POINT: exactly 1 tick.
  - Miss to next PLAY: 1+SERVE_DELAY ticks.
- Ticks on consecutive cycles are each honoured.
- With no tick, state and outputs hold.
- `rst` mid-match restores all reset values on the next edge and has priority over `start` and `timing_tick`.

## Test plan
- Reset, then hold `start`=0 for 10 ticks -> state 0, ball (395,295), paddles 250, scores 0, `winner` 0.
- Pulse `start` with SERVE_DELAY=3 -> state 1 on the next cycle; state 2 after the 3rd tick; ball at (399,299) after the first PLAY tick.
- Hold `p1_up` for 50 ticks -> `y_player1` steps 250,244,…,4,0, then stays 0. Hold both `p2_up` and `p2_down` -> `y_player2` constant.
- Ball in PLAY at y=2 moving up -> y=0 and direction down; the next tick gives y=4.
- Ball moving left at x=32, overlapping `y_player1` -> x=30, then x=34 next tick. The same with no overlap -> continues to x=0, `player2_score`=1, state 3, then SERVE with the ball moving left.
- WIN_SCORE=2, force two right misses -> `player1_score`=2, state 4, `winner`=1. Positions hold. Then `start` -> scores 0 and state 1.

Source files
------------

// File: rtl/pong_match_controller.sv
// Pong game core: ball motion, paddles, scoring and the match FSM, all advanced by the frame tick.
// Every output is a register; start from IDLE/GAME_OVER acts without waiting for a tick.
module pong_match_controller #(
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int PAD_H       = 100,
  parameter int PAD_W       = 10,
  parameter int PAD_X_LEFT  = 20,
  parameter int PAD_X_RIGHT = 770,
  parameter int BALL_SIZE   = 10,
  parameter int BALL_SPEED  = 4,
  parameter int PAD_SPEED   = 6,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4,
  parameter int SERVE_DELAY = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [10:0]        x_ball,
  output logic [9:0]         y_ball,
  output logic [9:0]         y_player1,
  output logic [9:0]         y_player2,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [2:0]         game_state,
  output logic [1:0]         winner
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int                 CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [10:0]        X_CTR    = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]         Y_CTR    = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]         PAD_CTR  = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  // Geometry held as signed 13-bit so that x - speed never wraps below zero.
  localparam logic signed [12:0] BSPD   = 13'(BALL_SPEED);
  localparam logic signed [12:0] BSZ    = 13'(BALL_SIZE);
  localparam logic signed [12:0] PADH   = 13'(PAD_H);
  localparam logic signed [12:0] X_MAX  = 13'(SCREEN_W - BALL_SIZE);
  localparam logic signed [12:0] Y_MAX  = 13'(SCREEN_H - BALL_SIZE);
  localparam logic signed [12:0] L_FACE = 13'(PAD_X_LEFT + PAD_W);
  localparam logic signed [12:0] R_FACE = 13'(PAD_X_RIGHT);
  localparam logic signed [12:0] R_HIT  = 13'(PAD_X_RIGHT - BALL_SIZE);
  localparam logic signed [12:0] ZERO   = 13'sd0;

  state_t             state, state_n;
  logic [10:0]        x_n;
  logic [9:0]         y_n, p1_n, p2_n;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic [1:0]         win_n;
  logic               dir_x, dir_y, serve_dir;
  logic               dx_n, dy_n, sd_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic signed [12:0] xs, ys, p1s, p2s, xt, yt;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic signed [11:0] t;
    t = $signed({2'b00, y});
    if (up && !dn) begin
      t = t - $signed(12'(PAD_SPEED));
      if (t < 12'sd0) t = 12'sd0;
    end else if (dn && !up) begin
      t = t + $signed(12'(PAD_SPEED));
      if (t > $signed(12'(SCREEN_H - PAD_H))) t = $signed(12'(SCREEN_H - PAD_H));
    end
    return 10'(t);
  endfunction

  function automatic logic overlap(input logic signed [12:0] yb, input logic signed [12:0] yp);
    return (yb + BSZ > yp) && (yb < yp + PADH);
  endfunction

  always_comb begin
    state_n = state;
    x_n     = x_ball;
    y_n     = y_ball;
    p1_n    = y_player1;
    p2_n    = y_player2;
    s1_n    = player1_score;
    s2_n    = player2_score;
    win_n   = winner;
    dx_n    = dir_x;
    dy_n    = dir_y;
    sd_n    = serve_dir;
    cnt_n   = cnt;
    xs      = $signed({2'b00, x_ball});
    ys      = $signed({3'b000, y_ball});
    p1s     = $signed({3'b000, y_player1});
    p2s     = $signed({3'b000, y_player2});
    xt      = xs;
    yt      = ys;
    if (start && (state == ST_IDLE || state == ST_OVER)) begin
      state_n = ST_SERVE;
      s1_n    = '0;
      s2_n    = '0;
      win_n   = 2'd0;
      x_n     = X_CTR;
      y_n     = Y_CTR;
      cnt_n   = '0;
      sd_n    = 1'b1;
    end else if (timing_tick) begin
      if (state == ST_SERVE || state == ST_PLAY) begin
        p1_n = pad_step(y_player1, p1_up, p1_down);
        p2_n = pad_step(y_player2, p2_up, p2_down);
      end
      case (state)
        ST_SERVE: begin
          x_n  = X_CTR;
          y_n  = Y_CTR;
          dx_n = serve_dir;
          if (cnt == CNT_LAST) begin
            state_n = ST_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (!dir_y) begin
            if (ys < BSPD) begin
              yt   = ZERO;
              dy_n = 1'b1;
            end else begin
              yt = ys - BSPD;
            end
          end else if (ys + BSPD > Y_MAX) begin
            yt   = Y_MAX;
            dy_n = 1'b0;
          end else begin
            yt = ys + BSPD;
          end
          // Paddle hits are tested before misses; overlap uses the pre-tick positions.
          if (!dir_x) begin
            if (xs >= L_FACE && xs - BSPD <= L_FACE && overlap(ys, p1s)) begin
              xt   = L_FACE;
              dx_n = 1'b1;
            end else if (xs < BSPD) begin
              xt      = ZERO;
              s2_n    = player2_score + SCORE_W'(1);
              sd_n    = 1'b0;
              state_n = ST_POINT;
            end else begin
              xt = xs - BSPD;
            end
          end else begin
            if (xs + BSZ <= R_FACE && xs + BSZ + BSPD >= R_FACE && overlap(ys, p2s)) begin
              xt   = R_HIT;
              dx_n = 1'b0;
            end else if (xs + BSPD > X_MAX) begin
              xt      = X_MAX;
              s1_n    = player1_score + SCORE_W'(1);
              sd_n    = 1'b1;
              state_n = ST_POINT;
            end else begin
              xt = xs + BSPD;
            end
          end
          x_n = 11'(xt);
          y_n = 10'(yt);
        end
        ST_POINT: begin
          // serve_dir points at the loser, so it also identifies who just scored.
          if (serve_dir ? (player1_score == WIN) : (player2_score == WIN)) begin
            state_n = ST_OVER;
            win_n   = serve_dir ? 2'd1 : 2'd2;
          end else begin
            x_n     = X_CTR;
            y_n     = Y_CTR;
            cnt_n   = '0;
            state_n = ST_SERVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      x_ball        <= X_CTR;
      y_ball        <= Y_CTR;
      y_player1     <= PAD_CTR;
      y_player2     <= PAD_CTR;
      player1_score <= '0;
      player2_score <= '0;
      winner        <= 2'd0;
      dir_x         <= 1'b1;
      dir_y         <= 1'b1;
      serve_dir     <= 1'b1;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      x_ball        <= x_n;
      y_ball        <= y_n;
      y_player1     <= p1_n;
      y_player2     <= p2_n;
      player1_score <= s1_n;
      player2_score <= s2_n;
      winner        <= win_n;
      dir_x         <= dx_n;
      dir_y         <= dy_n;
      serve_dir     <= sd_n;
      cnt           <= cnt_n;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: behavioural game model feeding a scoreboard queue, plus directed checks.
module tb_pong_match_controller;
  logic        clk = 1'b0;
  logic        rst, timing_tick, start, p1_up, p1_down, p2_up, p2_down;
  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_player1, y_player2;
  logic [3:0]  player1_score, player2_score;
  logic [2:0]  game_state;
  logic [1:0]  winner;

  always #5 clk = ~clk;

  pong_match_controller #(.SERVE_DELAY(3), .WIN_SCORE(2)) dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .x_ball(x_ball), .y_ball(y_ball), .y_player1(y_player1), .y_player2(y_player2),
    .player1_score(player1_score), .player2_score(player2_score),
    .game_state(game_state), .winner(winner)
  );

  typedef struct { int st; int x; int y; int p1; int p2; int s1; int s2; int win; } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  // Model state: dx/dy/sd = 1 means right/down/serve-right.
  int m_st, m_x, m_y, m_p1, m_p2, m_s1, m_s2, m_win, m_dx, m_dy, m_sd, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int mpad(input int y, input bit u, input bit d);
    if (u && !d) return (y - 6 < 0) ? 0 : y - 6;
    if (d && !u) return (y + 6 > 500) ? 500 : y + 6;
    return y;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit s,
                            input bit u1, input bit d1, input bit u2, input bit d2);
    int op1, op2, nx, ny;
    bit ov1, ov2;
    if (r) begin
      m_st = 0; m_x = 395; m_y = 295; m_p1 = 250; m_p2 = 250;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 1; m_dy = 1; m_sd = 1; m_cnt = 0;
    end else if (s && (m_st == 0 || m_st == 4)) begin
      m_st = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_x = 395; m_y = 295; m_cnt = 0; m_sd = 1;
    end else if (t) begin
      op1 = m_p1;
      op2 = m_p2;
      if (m_st == 1 || m_st == 2) begin
        m_p1 = mpad(op1, u1, d1);
        m_p2 = mpad(op2, u2, d2);
      end
      case (m_st)
        1: begin
          m_x = 395; m_y = 295; m_dx = m_sd;
          if (m_cnt == 2) begin m_st = 2; m_cnt = 0; end
          else m_cnt++;
        end
        2: begin
          ov1 = (m_y + 10 > op1) && (m_y < op1 + 100);
          ov2 = (m_y + 10 > op2) && (m_y < op2 + 100);
          if (m_dy == 0) begin
            if (m_y < 4) begin ny = 0; m_dy = 1; end
            else ny = m_y - 4;
          end else begin
            if (m_y + 4 > 590) begin ny = 590; m_dy = 0; end
            else ny = m_y + 4;
          end
          if (m_dx == 0) begin
            if (m_x >= 30 && m_x - 4 <= 30 && ov1) begin nx = 30; m_dx = 1; end
            else if (m_x < 4) begin nx = 0; m_s2++; m_sd = 0; m_st = 3; end
            else nx = m_x - 4;
          end else begin
            if (m_x + 10 <= 770 && m_x + 14 >= 770 && ov2) begin nx = 760; m_dx = 0; end
            else if (m_x + 4 > 790) begin nx = 790; m_s1++; m_sd = 1; m_st = 3; end
            else nx = m_x + 4;
          end
          m_x = nx;
          m_y = ny;
        end
        3: begin
          if ((m_sd == 1 && m_s1 == 2) || (m_sd == 0 && m_s2 == 2)) begin
            m_st = 4; m_win = (m_sd == 1) ? 1 : 2;
          end else begin
            m_x = 395; m_y = 295; m_st = 1; m_cnt = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit t, input bit s,
                      input bit u1, input bit d1, input bit u2, input bit d2);
    exp_t e;
    rst = r; timing_tick = t; start = s;
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    model_step(r, t, s, u1, d1, u2, d2);
    e.st = m_st; e.x = m_x; e.y = m_y; e.p1 = m_p1; e.p2 = m_p2;
    e.s1 = m_s1; e.s2 = m_s2; e.win = m_win;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", 32'(game_state), e.st);
    chk("x_ball", 32'(x_ball), e.x);
    chk("y_ball", 32'(y_ball), e.y);
    chk("y_player1", 32'(y_player1), e.p1);
    chk("y_player2", 32'(y_player2), e.p2);
    chk("p1_score", 32'(player1_score), e.s1);
    chk("p2_score", 32'(player2_score), e.s2);
    chk("winner", 32'(winner), e.win);
  endtask

  initial begin
    int cyc;
    int hx, hy;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("idle_state", 32'(game_state), 0);
    chk("idle_x", 32'(x_ball), 395);
    chk("idle_y", 32'(y_ball), 295);
    chk("idle_p1", 32'(y_player1), 250);
    chk("idle_p2", 32'(y_player2), 250);
    chk("idle_s1", 32'(player1_score), 0);
    chk("idle_s2", 32'(player2_score), 0);
    chk("idle_win", 32'(winner), 0);

    step(0, 0, 1, 0, 0, 0, 0);
    chk("start_state", 32'(game_state), 1);

    // p1 climbs to the top wall, p2 has both buttons held
    for (int k = 1; k <= 50; k++) begin
      step(0, 1, 0, 1, 0, 1, 1);
      chk("p1_climb", 32'(y_player1), (250 - 6 * k < 0) ? 0 : 250 - 6 * k);
      chk("p2_both", 32'(y_player2), 250);
      if (k == 2) chk("serve_hold", 32'(game_state), 1);
      if (k == 3) chk("play_entry", 32'(game_state), 2);
      if (k == 4) begin
        chk("first_x", 32'(x_ball), 399);
        chk("first_y", 32'(y_ball), 299);
      end
    end

    // p1 tracks the ball, p2 runs away from it; ticks are irregular
    cyc = 0;
    while (m_st != 4 && cyc < 20000) begin
      bit t, u1, d1, u2, d2;
      t  = ($urandom_range(3) != 0);
      u1 = (m_y + 5) < (m_p1 + 48);
      d1 = (m_y + 5) > (m_p1 + 52);
      u2 = (m_y + 5) > 300;
      d2 = !u2;
      if ($urandom_range(15) == 0) d2 = 1'b1;
      step(0, t, 0, u1, d1, u2, d2);
      cyc++;
    end
    chk("reach_game_over", 32'(cyc < 20000), 1);
    chk("over_state", 32'(game_state), 4);
    chk("over_winner_set", 32'(winner != 2'd0), 1);
    chk("over_win_score", (winner == 2'd1) ? 32'(player1_score) : 32'(player2_score), 2);

    hx = m_x;
    hy = m_y;
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("over_hold_x", 32'(x_ball), hx);
    chk("over_hold_y", 32'(y_ball), hy);
    chk("over_hold_state", 32'(game_state), 4);

    step(0, 0, 1, 0, 0, 0, 0);
    chk("restart_state", 32'(game_state), 1);
    chk("restart_s1", 32'(player1_score), 0);
    chk("restart_s2", 32'(player2_score), 0);
    chk("restart_win", 32'(winner), 0);

    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 0, 0, 1);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_x", 32'(x_ball), 395);
    chk("rst_p1", 32'(y_player1), 250);
    chk("rst_p2", 32'(y_player2), 250);
    step(0, 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
